// File: rtl/arashi_thread_tracker.sv
// rtl/arashi_thread_tracker.sv - per-thread READY/STALL/WAIT lifecycle tracker
// Produces the registered issue-eligible vector that feeds the thread arbiter.
module arashi_thread_tracker #(
   parameter int THREAD_NUM_WIDTH = 2,
   parameter int STALL_WIDTH      = 4,
   localparam int THREAD_NUM      = 1 << THREAD_NUM_WIDTH
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        start_valid,
   input  logic [THREAD_NUM_WIDTH-1:0] start_tid,
   input  logic                        grant_valid,
   input  logic [THREAD_NUM_WIDTH-1:0] grant_tid,
   input  logic [STALL_WIDTH-1:0]      grant_stall,
   input  logic                        grant_wait,
   input  logic                        wake_valid,
   input  logic [THREAD_NUM_WIDTH-1:0] wake_tid,
   input  logic                        kill_valid,
   input  logic [THREAD_NUM_WIDTH-1:0] kill_tid,
   output logic [THREAD_NUM-1:0]       avail,
   output logic [THREAD_NUM_WIDTH:0]   active_cnt,
   output logic                        err
);

   typedef enum logic [1:0] {
      T_IDLE  = 2'd0,
      T_READY = 2'd1,
      T_STALL = 2'd2,
      T_WAIT  = 2'd3
   } thread_state_t;

   thread_state_t            state_q [THREAD_NUM];
   thread_state_t            state_d [THREAD_NUM];
   logic [STALL_WIDTH-1:0]   cnt_q   [THREAD_NUM];
   logic [STALL_WIDTH-1:0]   cnt_d   [THREAD_NUM];
   logic [THREAD_NUM-1:0]    start_hit, grant_hit, wake_hit, kill_hit;
   logic [THREAD_NUM_WIDTH:0] active_d;
   logic                     err_d;

   always_comb begin
      for (int i = 0; i < THREAD_NUM; i++) begin
         start_hit[i] = start_valid && (start_tid == THREAD_NUM_WIDTH'(i));
         grant_hit[i] = grant_valid && (grant_tid == THREAD_NUM_WIDTH'(i));
         wake_hit[i]  = wake_valid  && (wake_tid  == THREAD_NUM_WIDTH'(i));
         kill_hit[i]  = kill_valid  && (kill_tid  == THREAD_NUM_WIDTH'(i));
      end
   end

   always_comb begin
      err_d    = err;
      active_d = '0;
      for (int i = 0; i < THREAD_NUM; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];

         // Stall countdown runs unless a winning event overrides it below.
         if (state_q[i] == T_STALL) begin
            if (cnt_q[i] <= STALL_WIDTH'(1)) begin
               state_d[i] = T_READY;
               cnt_d[i]   = '0;
            end else begin
               cnt_d[i] = cnt_q[i] - STALL_WIDTH'(1);
            end
         end

         if (kill_hit[i]) begin
            state_d[i] = T_IDLE;
            cnt_d[i]   = '0;
         end else if (grant_hit[i]) begin
            if (state_q[i] == T_READY) begin
               if (grant_wait) begin
                  state_d[i] = T_WAIT;
                  cnt_d[i]   = '0;
               end else if (grant_stall != '0) begin
                  state_d[i] = T_STALL;
                  cnt_d[i]   = grant_stall;
               end
            end
         end else if (wake_hit[i]) begin
            if (state_q[i] == T_WAIT) state_d[i] = T_READY;
         end else if (start_hit[i]) begin
            if (state_q[i] == T_IDLE) state_d[i] = T_READY;
         end

         if (start_hit[i] && (kill_hit[i] || state_q[i] != T_IDLE)) err_d = 1'b1;
         if (grant_hit[i] && state_q[i] != T_READY) err_d = 1'b1;

         active_d = active_d + {{THREAD_NUM_WIDTH{1'b0}}, (state_d[i] != T_IDLE)};
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < THREAD_NUM; i++) begin
            state_q[i] <= T_IDLE;
            cnt_q[i]   <= '0;
         end
         active_cnt <= '0;
         err        <= 1'b0;
      end else begin
         for (int i = 0; i < THREAD_NUM; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         active_cnt <= active_d;
         err        <= err_d;
      end
   end

   always_comb begin
      for (int i = 0; i < THREAD_NUM; i++) avail[i] = (state_q[i] == T_READY);
   end

endmodule
